// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared sequencer state encoding and index-width helper
package nn_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CALC, WAIT, NEXT} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addr_counter.sv
// addr_counter: address up-counter with enable, sync clear and terminal compare against a length
module addr_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt  = cnt_q;
  assign last = {1'b0, cnt_q} == len - 1'b1;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps through layers, sweeps per-layer addresses, handshakes completion and abort
module layer_sequencer import nn_ctrl_pkg::*; #(
  parameter int LAYER_COUNT = 4,
  parameter int LAYER_IDX_W = idx_w(LAYER_COUNT),
  parameter int ADDR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LAYER_IDX_W:0]   num_layers,
  input  logic [ADDR_W:0]        layer_len,
  input  logic                   stall,
  input  logic                   layer_done,
  input  logic                   abort,
  output logic                   ready,
  output logic                   busy,
  output logic                   layer_rst,
  output logic [LAYER_IDX_W-1:0] layer_index,
  output logic [ADDR_W-1:0]      addr,
  output logic                   addr_valid,
  output logic                   last_addr,
  output logic                   done
);
  localparam logic [LAYER_IDX_W:0] MAX_L = (LAYER_IDX_W + 1)'(LAYER_COUNT);
  state_t                 state_q, state_d;
  logic [LAYER_IDX_W:0]   n_q, n_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic [LAYER_IDX_W-1:0] idx_q, idx_d;
  logic                   seen_q, seen_d, cnt_last, final_layer, kill;
  assign kill        = abort && state_q != IDLE;
  assign final_layer = {1'b0, idx_q} == n_q - 1'b1;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    len_d   = len_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    case (state_q)
      IDLE: if (start && !abort && num_layers != '0) begin
        state_d = LOAD;
        n_d     = num_layers > MAX_L ? MAX_L : num_layers;
      end
      LOAD: begin
        len_d   = layer_len;
        seen_d  = 1'b0;
        state_d = layer_len != '0 ? CALC : WAIT;
      end
      CALC: begin
        seen_d  = seen_q || layer_done;
        state_d = addr_valid && last_addr ? WAIT : CALC;
      end
      WAIT: state_d = layer_done || seen_q ? NEXT : WAIT;
      NEXT: begin
        state_d = final_layer ? IDLE : LOAD;
        idx_d   = final_layer ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      idx_d   = '0;
      seen_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
    end
  end
  addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (addr_valid),
    .clr  (kill || (addr_valid && last_addr)),
    .len  (len_q),
    .cnt  (addr),
    .last (cnt_last)
  );
  assign ready       = state_q == IDLE;
  assign busy        = !ready;
  assign layer_rst   = state_q == IDLE || state_q == LOAD;
  assign layer_index = idx_q;
  assign addr_valid  = state_q == CALC && !stall;
  assign last_addr   = state_q == CALC && cnt_last;
  assign done        = state_q == NEXT && final_layer;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed runs checked against an address/done-timing model of the sequencer
module tb_layer_sequencer;
  logic       clk = 0, rst = 1, start = 0, stall = 0, layer_done = 1, abort = 0;
  logic [2:0] num_layers = 0;
  logic [8:0] layer_len;
  logic [8:0] lens [4];
  logic       ready, busy, layer_rst, addr_valid, last_addr, done;
  logic [1:0] layer_index;
  logic [7:0] addr;
  int cyc = 0, t0 = 0, checks = 0, errors = 0;
  int e_idx [2048], e_addr [2048], e_last [2048];
  int wr = 0, rd = 0, exp_done_cyc = -1, exp_done_n = 0, done_n = 0, last_done_cyc = -1;
  int load_cnt = 0, load0 = 0, loads_exp = 0;
  bit mon_en = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign layer_len = lens[layer_index];
  layer_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_layers  (num_layers),
    .layer_len   (layer_len),
    .stall       (stall),
    .layer_done  (layer_done),
    .abort       (abort),
    .ready       (ready),
    .busy        (busy),
    .layer_rst   (layer_rst),
    .layer_index (layer_index),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .last_addr   (last_addr),
    .done        (done)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int cy;
    cy = cyc - t0 + 1;
    if (mon_en) begin
      chk("ready_vs_busy", int'(ready), int'(!busy));
      if (ready) begin
        chk("idle_addr", int'(addr), 0);
        chk("idle_index", int'(layer_index), 0);
        chk("idle_layer_rst", int'(layer_rst), 1);
        chk("idle_addr_valid", int'(addr_valid), 0);
        chk("idle_last_addr", int'(last_addr), 0);
      end
      if (addr_valid) begin
        if (rd >= wr) chk("unexpected_addr", 1, 0);
        else begin
          chk("addr_index", int'(layer_index), e_idx[rd]);
          chk("addr_value", int'(addr), e_addr[rd]);
          chk("addr_last", int'(last_addr), e_last[rd]);
          rd++;
        end
      end
      if (busy && layer_rst) load_cnt++;
      if (done) begin
        done_n++;
        last_done_cyc = cy;
        chk("done_cycle", cy, exp_done_cyc);
      end
    end
  end
  task automatic push_layer(input int idx, input int len, input int upto);
    for (int a = 0; a < upto; a++) begin
      e_idx[wr]  = idx;
      e_addr[wr] = a;
      e_last[wr] = int'(a == len - 1);
      wr++;
    end
  endtask
  task automatic plan(input int n, input int extra);
    int nl;
    int sum;
    nl  = n > 4 ? 4 : n;
    sum = 0;
    for (int i = 0; i < nl; i++) begin
      push_layer(i, int'(lens[i]), int'(lens[i]));
      sum += int'(lens[i]) + 3;
    end
    exp_done_cyc = sum + extra;
    exp_done_n++;
    loads_exp = nl;
  endtask
  task automatic launch(input int n);
    load0 = load_cnt;
    @(posedge clk);
    #1 num_layers = 3'(n);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
  endtask
  task automatic goto(input int k);
    while (cyc - t0 + 1 < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle;
    int k;
    k = 0;
    while (!ready && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_reached", int'(ready), 1);
  endtask
  task automatic close_run;
    chk("addr_count", rd, wr);
    chk("done_count", done_n, exp_done_n);
    chk("load_cycles", load_cnt - load0, loads_exp);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    lens[0] = 4; lens[1] = 2; lens[2] = 5; lens[3] = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    t0 = cyc;
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_layer_rst", int'(layer_rst), 1);
    chk("reset_addr", int'(addr), 0);
    chk("reset_index", int'(layer_index), 0);
    chk("reset_addr_valid", int'(addr_valid), 0);
    chk("reset_last_addr", int'(last_addr), 0);
    chk("reset_done", int'(done), 0);
    mon_en = 1;
    plan(3, 0);
    launch(3);
    goto(1);
    chk("load_layer_rst", int'(layer_rst), 1);
    wait_idle;
    close_run;
    chk("run3_done_literal", last_done_cyc, 20);
    lens[0] = 4;
    plan(1, 3);
    launch(1);
    goto(4);
    stall = 1;
    goto(5);
    chk("stall_addr_hold", int'(addr), 2);
    chk("stall_valid_low", int'(addr_valid), 0);
    goto(7);
    stall = 0;
    wait_idle;
    close_run;
    chk("stall_done_literal", last_done_cyc, 10);
    lens[0] = 3; lens[1] = 0; lens[2] = 2;
    plan(3, 0);
    launch(3);
    wait_idle;
    close_run;
    chk("len0_done_literal", last_done_cyc, 14);
    layer_done = 0;
    lens[0] = 4;
    plan(1, 0);
    launch(1);
    goto(3);
    layer_done = 1;
    goto(4);
    layer_done = 0;
    wait_idle;
    close_run;
    chk("latched_done_literal", last_done_cyc, 7);
    lens[0] = 3;
    plan(1, 3);
    launch(1);
    goto(7);
    chk("wait_holds", int'(busy), 1);
    goto(8);
    layer_done = 1;
    wait_idle;
    close_run;
    lens[0] = 1; lens[1] = 1; lens[2] = 1; lens[3] = 1;
    plan(7, 0);
    launch(7);
    wait_idle;
    close_run;
    chk("clamp_done_literal", last_done_cyc, 16);
    lens[0] = 9'd256;
    plan(1, 0);
    launch(1);
    wait_idle;
    close_run;
    chk("len256_done_literal", last_done_cyc, 259);
    lens[0] = 4; lens[1] = 2; lens[2] = 5;
    push_layer(0, 4, 4);
    push_layer(1, 2, 1);
    loads_exp = 2;
    launch(3);
    goto(9);
    abort = 1;
    start = 1;
    goto(10);
    abort = 0;
    start = 0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_addr", int'(addr), 0);
    chk("abort_index", int'(layer_index), 0);
    goto(11);
    chk("abort_start_ignored", int'(busy), 0);
    close_run;
    lens[0] = 2;
    plan(1, 0);
    launch(1);
    wait_idle;
    close_run;
    layer_done = 0;
    lens[0] = 3;
    push_layer(0, 3, 3);
    loads_exp = 1;
    launch(1);
    goto(6);
    rst = 1;
    goto(7);
    rst = 0;
    layer_done = 1;
    chk("rst_ready", int'(ready), 1);
    close_run;
    lens[0] = 1;
    plan(1, 0);
    launch(1);
    wait_idle;
    close_run;
    chk("after_rst_done_literal", last_done_cyc, 4);
    @(posedge clk);
    #1 num_layers = 0;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("zero_layers_ignored", int'(busy), 0);
    num_layers = 2;
    start = 1;
    abort = 1;
    @(posedge clk);
    #1 start = 0;
    abort = 0;
    chk("start_with_abort_ignored", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_done_count", done_n, exp_done_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
